mips_ex_mem_unit: RTL and testbench
===================================

Name: mips_ex_mem_unit

Overview:
- Combined execute/memory-stage datapath for the 5-stage MIPS pipeline.
- Contains three parts:
  - an ALU-control decoder that maps opcode/funct to a 3-bit ALU operation;
  - a 32-bit combinational ALU fed by the already-forwarded operands of the EX stage;
  - a word-addressed data memory driven by the EX/MEM pipeline fields.
- The pipeline registers (ID/EX, EX/MEM, MEM/WB) and the forwarding muxes stay outside this block.

Parameters:
- DEPTH, 64, number of 32-bit data-memory words (power of two).
- AW, 6, word-index width = log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ex_op  in  6  opcode of the instruction in EX (IDEXIR[31:26])
- ex_funct  in  6  funct field of the instruction in EX (IDEXIR[5:0])
- alu_a  in  32  forwarded operand A
- alu_b  in  32  forwarded operand B (immediate already selected externally)
- alu_ctrl  out  3  decoded ALU operation
- alu_result  out  32  ALU result (combinational)
- alu_zero  out  1  high when alu_result == 0
- mem_op  in  6  opcode of the instruction in MEM (EXMEMIR[31:26])
- mem_addr  in  32  byte address (EX/MEM ALU output)
- mem_wdata  in  32  store data (EX/MEM B register)
- mem_rdata  out  32  load data
- mem_stage_out  out  32  value forwarded to MEM/WB: mem_rdata if mem_op is LW, otherwise mem_addr

Behaviour:
- Opcodes:
  - R-type = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000.
  - J = 000010, JAL = 000011.
- ALU control codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
- Decoder (purely combinational):
  - LW, SW, ADDI -> ADD; BEQ -> SUB.
  - R-type decodes funct:
    - 100000 -> ADD, 100010 -> SUB.
    - 100100 -> AND, 100101 -> OR.
    - 100111 -> NOR, 101010 -> SLT.
    - Any other funct (including JR 001000) -> ADD.
  - J, JAL and all other opcodes -> ADD.
- ALU:
  - Purely combinational; the clock is not used by the ALU; the output settles in the same cycle.
  - ADD/SUB wrap modulo 2^32; overflow is ignored and not flagged.
  - SLT is signed two's-complement: the result is 32'd1 if alu_a < alu_b, else 32'd0.
  - NOR = ~(alu_a | alu_b).
  - alu_zero = (alu_result == 0).
- Data memory storage:
  - DEPTH x 32 array.
  - Word index = mem_addr[AW+1:2]. Bits [1:0] are ignored (no alignment fault). Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Data memory write:
  - Synchronous, on the rising clock edge, when mem_op == SW.
  - mem_wdata is written to the indexed word.
  - No byte enables.
- Data memory read:
  - Asynchronous: mem_rdata = array[index] when mem_op == LW, else 32'd0.
  - Read-during-write is impossible within one instruction (LW and SW are exclusive). A read issued after a write sees the new value in the following cycle.
- mem_stage_out: a combinational 2:1 mux selected only by mem_op == LW.
- Reset:
  - reset_n low asynchronously clears every memory word to 0, independent of clock.
  - Writes are blocked while reset_n is low.
  - Combinational outputs follow their inputs during reset. mem_rdata reads 0 because the array is cleared.
  - Reset deassertion mid-operation: the first rising edge with reset_n high may perform a SW.
- No other state exists in the block.

Test Plan:
- Reset: hold reset_n=0, then release. mem_op=LW at addr 0, 4, 252 -> mem_rdata = 0 for each; mem_stage_out = 0.
- Decoder sweep:
  - ex_op=0 with funct 0x20/0x22/0x24/0x25/0x27/0x2A -> alu_ctrl 010/110/000/001/100/111.
  - ex_op LW/SW/ADDI -> 010; BEQ -> 110; funct 0x08 -> 010.
- ALU arithmetic:
  - ADD 0xFFFFFFFF+1 -> 0, zero=1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT -1 vs 1 -> 1; SLT 1 vs -1 -> 0.
  - AND 0xF0F0 & 0xFF00 -> 0xF000.
  - NOR 0,0 -> 0xFFFFFFFF.
- Store/load:
  - SW addr 8 data 0x12345678, then LW addr 8 -> mem_rdata = 0x12345678 and mem_stage_out = 0x12345678.
  - LW addr 9 -> same word (low bits ignored).
- Wrap and pass-through:
  - SW addr 256 data 0xAA -> LW addr 0 returns 0xAA (DEPTH=64).
  - mem_op=R-type with mem_addr=0x55 -> mem_stage_out = 0x55, mem_rdata = 0, and no write occurs.
- Asynchronous reset mid-run: after several stores, pulse reset_n low between clock edges -> all words read 0 immediately; a SW on the same edges while reset_n is low is not written.

Source files
------------

// File: rtl/mips_ex_mem_unit.sv
// mips_ex_mem_unit
//   Execute/memory-stage datapath for the 5-stage MIPS pipeline. It holds the
//   ALU-control decoder, the 32-bit combinational ALU and a word-addressed
//   data memory. Pipeline registers and forwarding muxes live outside.
//
// Ports:
//   clock          rising-edge clock (used only by data-memory writes)
//   reset_n        asynchronous active-low reset, clears the data memory
//   ex_op          opcode of the instruction in EX
//   ex_funct       funct field of the instruction in EX
//   alu_a, alu_b   forwarded ALU operands (immediate already selected)
//   alu_ctrl       decoded 3-bit ALU operation
//   alu_result     combinational ALU result
//   alu_zero       high when alu_result is zero
//   mem_op         opcode of the instruction in MEM
//   mem_addr       byte address from the EX/MEM ALU output
//   mem_wdata      store data from the EX/MEM B register
//   mem_rdata      load data (zero unless mem_op is LW)
//   mem_stage_out  mem_rdata for LW, otherwise mem_addr
module mips_ex_mem_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  ex_op,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_stage_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic          is_lw;
  logic          is_sw;
  logic          unused_addr_bits;

  // ALU-control decoder. Loads, stores and ADDI compute an address/sum,
  // BEQ compares by subtraction, and every unrecognised opcode or funct
  // (J, JAL, JR, ...) falls back to ADD so the ALU output is harmless.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ex_op)
      OP_LW, OP_SW, OP_ADDI: alu_ctrl = ALU_ADD;
      OP_BEQ:                alu_ctrl = ALU_SUB;
      OP_RTYPE: begin
        case (ex_funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // 32-bit ALU. ADD/SUB wrap silently; SLT compares as signed values.
  // The two unused control codes produce zero.
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // Byte offset and upper address bits are dropped, so addresses wrap
  // modulo DEPTH*4 and misaligned addresses hit the containing word.
  assign word_idx         = mem_addr[AW+1:2];
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};
  assign is_lw            = (mem_op == OP_LW);
  assign is_sw            = (mem_op == OP_SW);

  // Data memory: the whole array is cleared while reset_n is low, which
  // also blocks stores; otherwise a SW writes the full word on the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (is_sw) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  // Asynchronous read, gated to zero for anything other than LW.
  assign mem_rdata     = is_lw ? mem[word_idx] : 32'd0;
  assign mem_stage_out = is_lw ? mem_rdata : mem_addr;

endmodule

// File: tb/tb_mips_ex_mem_unit.sv
// tb_mips_ex_mem_unit
//   Directed-vector bench for mips_ex_mem_unit: reset state, decoder sweep,
//   ALU arithmetic corner cases, store/load, address wrap, pass-through and
//   an asynchronous reset pulse in the middle of a run.
module tb_mips_ex_mem_unit;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  logic        clock;
  logic        reset_n;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_stage_out;

  int total;
  int bad;

  mips_ex_mem_unit #(.DEPTH(64), .AW(6)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ex_op         (ex_op),
    .ex_funct      (ex_funct),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .mem_op        (mem_op),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_stage_out (mem_stage_out)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one memory-side operation on the falling edge and lets the
  // combinational outputs settle before anyone samples them.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(negedge clock);
    mem_op    = op;
    mem_addr  = addr;
    mem_wdata = wdata;
    #1;
  endtask

  // Stores a word: drive SW, then let one rising edge commit it.
  task automatic storeWord(input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(OP_SW, addr, wdata);
    @(posedge clock);
    #1;
  endtask

  // Decoder sweep vectors: opcode, funct, expected alu_ctrl.
  logic [5:0] dec_op    [12];
  logic [5:0] dec_funct [12];
  logic [2:0] dec_exp   [12];

  // Main directed sequence.
  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    ex_op     = OP_RTYPE;
    ex_funct  = 6'h20;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    mem_op    = OP_RTYPE;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset state: every probed word reads zero.
    applyStimulus(OP_LW, 32'd0, 32'd0);
    checkOutput("rst_rdata_0", mem_rdata, 32'd0);
    checkOutput("rst_stage_0", mem_stage_out, 32'd0);
    applyStimulus(OP_LW, 32'd4, 32'd0);
    checkOutput("rst_rdata_4", mem_rdata, 32'd0);
    checkOutput("rst_stage_4", mem_stage_out, 32'd0);
    applyStimulus(OP_LW, 32'd252, 32'd0);
    checkOutput("rst_rdata_252", mem_rdata, 32'd0);
    checkOutput("rst_stage_252", mem_stage_out, 32'd0);

    // Decoder sweep.
    dec_op[0]  = OP_RTYPE; dec_funct[0]  = 6'h20; dec_exp[0]  = 3'b010;
    dec_op[1]  = OP_RTYPE; dec_funct[1]  = 6'h22; dec_exp[1]  = 3'b110;
    dec_op[2]  = OP_RTYPE; dec_funct[2]  = 6'h24; dec_exp[2]  = 3'b000;
    dec_op[3]  = OP_RTYPE; dec_funct[3]  = 6'h25; dec_exp[3]  = 3'b001;
    dec_op[4]  = OP_RTYPE; dec_funct[4]  = 6'h27; dec_exp[4]  = 3'b100;
    dec_op[5]  = OP_RTYPE; dec_funct[5]  = 6'h2A; dec_exp[5]  = 3'b111;
    dec_op[6]  = OP_LW;    dec_funct[6]  = 6'h22; dec_exp[6]  = 3'b010;
    dec_op[7]  = OP_SW;    dec_funct[7]  = 6'h24; dec_exp[7]  = 3'b010;
    dec_op[8]  = OP_ADDI;  dec_funct[8]  = 6'h2A; dec_exp[8]  = 3'b010;
    dec_op[9]  = OP_BEQ;   dec_funct[9]  = 6'h20; dec_exp[9]  = 3'b110;
    dec_op[10] = OP_RTYPE; dec_funct[10] = 6'h08; dec_exp[10] = 3'b010;
    dec_op[11] = OP_JAL;   dec_funct[11] = 6'h22; dec_exp[11] = 3'b010;
    for (int i = 0; i < 12; i++) begin
      ex_op    = dec_op[i];
      ex_funct = dec_funct[i];
      #1;
      checkOutput($sformatf("dec_%0d", i), {29'd0, alu_ctrl}, {29'd0, dec_exp[i]});
    end
    ex_op = OP_J; ex_funct = 6'h27;
    #1;
    checkOutput("dec_j", {29'd0, alu_ctrl}, 32'd2);

    // ALU arithmetic corner cases.
    ex_op = OP_RTYPE;
    ex_funct = 6'h20; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1; #1;
    checkOutput("add_wrap", alu_result, 32'd0);
    checkOutput("add_zero", {31'd0, alu_zero}, 32'd1);
    ex_funct = 6'h22; alu_a = 32'd5; alu_b = 32'd7; #1;
    checkOutput("sub_neg", alu_result, 32'hFFFF_FFFE);
    checkOutput("sub_nonzero", {31'd0, alu_zero}, 32'd0);
    ex_funct = 6'h2A; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1; #1;
    checkOutput("slt_m1_1", alu_result, 32'd1);
    alu_a = 32'd1; alu_b = 32'hFFFF_FFFF; #1;
    checkOutput("slt_1_m1", alu_result, 32'd0);
    ex_funct = 6'h24; alu_a = 32'h0000_F0F0; alu_b = 32'h0000_FF00; #1;
    checkOutput("and", alu_result, 32'h0000_F000);
    ex_funct = 6'h27; alu_a = 32'd0; alu_b = 32'd0; #1;
    checkOutput("nor", alu_result, 32'hFFFF_FFFF);
    ex_funct = 6'h25; alu_a = 32'h1200_0034; alu_b = 32'h0056_0000; #1;
    checkOutput("or", alu_result, 32'h1256_0034);

    // Store then load, including a misaligned address into the same word.
    storeWord(32'd8, 32'h1234_5678);
    applyStimulus(OP_LW, 32'd8, 32'd0);
    checkOutput("lw8_rdata", mem_rdata, 32'h1234_5678);
    checkOutput("lw8_stage", mem_stage_out, 32'h1234_5678);
    applyStimulus(OP_LW, 32'd9, 32'd0);
    checkOutput("lw9_rdata", mem_rdata, 32'h1234_5678);

    // Address wrap: byte address 256 lands on word 0.
    storeWord(32'd256, 32'h0000_00AA);
    applyStimulus(OP_LW, 32'd0, 32'd0);
    checkOutput("wrap_lw0", mem_rdata, 32'h0000_00AA);
    applyStimulus(OP_LW, 32'd8, 32'd0);
    checkOutput("wrap_keep8", mem_rdata, 32'h1234_5678);

    // Non-memory op passes the address through and writes nothing.
    applyStimulus(OP_RTYPE, 32'h55, 32'hDEAD_BEEF);
    checkOutput("pass_stage", mem_stage_out, 32'h55);
    checkOutput("pass_rdata", mem_rdata, 32'd0);
    @(posedge clock);
    applyStimulus(OP_LW, 32'h54, 32'd0);
    checkOutput("pass_nowrite", mem_rdata, 32'd0);

    // Asynchronous reset pulse between edges, with a blocked store.
    storeWord(32'd12, 32'h0000_0077);
    storeWord(32'd16, 32'h0000_0088);
    applyStimulus(OP_LW, 32'd12, 32'd0);
    checkOutput("pre_rst_12", mem_rdata, 32'h0000_0077);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_clr_12", mem_rdata, 32'd0);
    mem_op = OP_SW; mem_addr = 32'd20; mem_wdata = 32'h0000_0099;
    @(posedge clock);
    #1;
    applyStimulus(OP_LW, 32'd20, 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_blocks_sw", mem_rdata, 32'd0);
    applyStimulus(OP_LW, 32'd16, 32'd0);
    checkOutput("async_clr_16", mem_rdata, 32'd0);
    applyStimulus(OP_LW, 32'd8, 32'd0);
    checkOutput("async_clr_8", mem_rdata, 32'd0);

    // First edge after reset release may store.
    storeWord(32'd24, 32'h0000_005A);
    applyStimulus(OP_LW, 32'd24, 32'd0);
    checkOutput("post_rst_sw", mem_rdata, 32'h0000_005A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
